// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache controller.
//   state_t      : controller FSM states
//   LINE_BITS    : refill line width (four 32-bit words)
//   OFFSET_BITS  : word-offset field width inside a line
//   helpers      : address-field positions and word selection
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MISS   = 2'd1,
    REFILL = 2'd2
  } state_t;

  localparam int ADDR_BITS   = 32;
  localparam int WORD_BITS   = 32;
  localparam int LINE_BITS   = 128;
  localparam int OFFSET_BITS = 2;
  localparam int OFFSET_LSB  = 2;
  localparam int INDEX_LSB   = OFFSET_LSB + OFFSET_BITS;

  function automatic logic [WORD_BITS-1:0] sel_word(input logic [LINE_BITS-1:0] line,
                                                    input logic [OFFSET_BITS-1:0] off);
    return line[{off, 5'b00000} +: WORD_BITS];
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag / valid / data storage for the direct-mapped instruction cache.
//   clk_i, rst_i         : clock, synchronous active-high reset (clears valid bits)
//   clr_i                : invalidate every line at this edge
//   rd_idx_i             : lookup index; rd_valid_o/rd_tag_o/rd_data_o are combinational
//   wr_en_i, wr_idx_i,
//   wr_tag_i, wr_data_i  : line install; sets the line valid at this edge
// An install in the same cycle as clr_i still leaves the installed line valid.
module icache_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_BITS  = $clog2(NUM_LINES),
  parameter int TAG_BITS  = ADDR_BITS - INDEX_LSB - IDX_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic [IDX_BITS-1:0]  rd_idx_i,
  output logic                 rd_valid_o,
  output logic [TAG_BITS-1:0]  rd_tag_o,
  output logic [LINE_BITS-1:0] rd_data_o,
  input  logic                 wr_en_i,
  input  logic [IDX_BITS-1:0]  wr_idx_i,
  input  logic [TAG_BITS-1:0]  wr_tag_i,
  input  logic [LINE_BITS-1:0] wr_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      if (clr_i) valid_q <= '0;
      // placed after the clear so an in-flight install survives a flush
      if (wr_en_i) valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with blocking single-line refill.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   req_i, addr_i      : fetch request and word-aligned PC
//   flush_i            : invalidate all lines (a same-cycle hit is still served)
//   instr_o, stall_o   : fetched word (0 unless served) and fetch-not-served
//   mem_req_o,
//   mem_addr_o         : refill request and 16-byte aligned line address
//   mem_ack_i,
//   mem_data_i         : single-cycle refill response, word 0 in [31:0]
//   hit_cnt_o,
//   miss_cnt_o         : hit / miss counters, present only with ICACHE_STATS_EN
//
// state  | meaning
// IDLE   | lookups served; a miss latches the line address and stalls
// MISS   | refill requested; waits for mem_ack_i, then installs the line
// REFILL | one bubble so the retried lookup sees the installed line
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic                 flush_i,
  output logic [WORD_BITS-1:0] instr_o,
  output logic                 stall_o,
  output logic                 mem_req_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  input  logic                 mem_ack_i,
  input  logic [LINE_BITS-1:0] mem_data_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = ADDR_BITS - INDEX_LSB - IDX_BITS;

  state_t state_q, state_d;
  logic [ADDR_BITS-INDEX_LSB-1:0] miss_line_q;

  logic                 rd_valid;
  logic [TAG_BITS-1:0]  rd_tag;
  logic [LINE_BITS-1:0] rd_data;
  logic                 hit;
  logic                 miss_start;
  logic                 wr_en;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^addr_i[OFFSET_LSB-1:0];

  icache_array #(
    .NUM_LINES (NUM_LINES)
  ) u_array (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (flush_i),
    .rd_idx_i   (addr_i[INDEX_LSB +: IDX_BITS]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_idx_i   (miss_line_q[IDX_BITS-1:0]),
    .wr_tag_i   (miss_line_q[IDX_BITS +: TAG_BITS]),
    .wr_data_i  (mem_data_i)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      miss_line_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) miss_line_q <= addr_i[ADDR_BITS-1:INDEX_LSB];
    end
  end

  always_comb begin
    state_d    = state_q;
    hit        = 1'b0;
    miss_start = 1'b0;
    wr_en      = 1'b0;
    stall_o    = 1'b1;
    instr_o    = '0;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    case (state_q)
      IDLE: begin
        hit        = req_i && rd_valid && (rd_tag == addr_i[ADDR_BITS-1 -: TAG_BITS]);
        miss_start = req_i && !hit;
        stall_o    = miss_start;
        if (hit) instr_o = sel_word(rd_data, addr_i[OFFSET_LSB +: OFFSET_BITS]);
        if (miss_start) state_d = MISS;
      end
      MISS: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {miss_line_q, 4'b0000};
        // a reset in the ack cycle aborts the refill without installing
        wr_en      = mem_ack_i && !rst_i;
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit)        hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (miss_start) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios followed by random
// fetch/flush/idle traffic against a line-level reference model.
module tb_icache_ctrl;

  localparam int NUM_LINES = 16;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         req_i = 1'b0;
  logic [31:0]  addr_i = '0;
  logic         flush_i = 1'b0;
  logic [31:0]  instr_o;
  logic         stall_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_ack_i = 1'b0;
  logic [127:0] mem_data_i = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  icache_ctrl #(.NUM_LINES(NUM_LINES)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .addr_i     (addr_i),
    .flush_i    (flush_i),
    .instr_o    (instr_o),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_data_i (mem_data_i)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: which memory line (address / 16) each slot holds
  bit           m_valid [NUM_LINES];
  int unsigned  m_line  [NUM_LINES];
  logic [127:0] backing [int unsigned];
  int unsigned  exp_hits   = 0;
  int unsigned  exp_misses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] line_word(input logic [127:0] line, input logic [31:0] a);
    int off;
    off = int'(a[3:2]);
    return line[off*32 +: 32];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; req_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_memreq", {31'd0, mem_req_o}, 32'd0);
    check("rst_instr", instr_o, 32'd0);
    rst_i = 1'b0;
    model_clear();
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic idle_cycle(input bit stray_ack);
    @(negedge clk_i);
    req_i = 1'b0; flush_i = 1'b0; mem_ack_i = stray_ack;
    mem_data_i = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("idle_stall", {31'd0, stall_o}, 32'd0);
    check("idle_instr", instr_o, 32'd0);
    check("idle_memreq", {31'd0, mem_req_o}, 32'd0);
  endtask

  // One fetch, followed through to the served cycle. dly = MISS cycles up to
  // and including the ack cycle.
  task automatic fetch(input logic [31:0] a, input int dly, input bit fl);
    int unsigned  la;
    int           idx;
    bit           was_hit;
    logic [127:0] line;
    int           stalls;
    la  = a >> 4;
    idx = int'(la % NUM_LINES);
    if (!backing.exists(la)) backing[la] = {$urandom, $urandom, $urandom, $urandom};
    line    = backing[la];
    was_hit = m_valid[idx] && (m_line[idx] == la);

    @(negedge clk_i);
    req_i = 1'b1; addr_i = a; flush_i = fl; mem_ack_i = 1'b0;
    #1;
    if (fl) model_clear();
    if (was_hit) begin
      check("hit_stall", {31'd0, stall_o}, 32'd0);
      check("hit_instr", instr_o, line_word(line, a));
      check("hit_memreq", {31'd0, mem_req_o}, 32'd0);
      exp_hits++;
    end else begin
      check("miss_stall", {31'd0, stall_o}, 32'd1);
      check("miss_instr", instr_o, 32'd0);
      check("miss_memreq0", {31'd0, mem_req_o}, 32'd0);
      exp_misses++;
      stalls = 1;
      for (int i = 1; i <= dly; i++) begin
        @(negedge clk_i);
        flush_i = 1'b0;
        mem_ack_i = (i == dly);
        mem_data_i = (i == dly) ? line : ~line;
        #1;
        check("memreq", {31'd0, mem_req_o}, 32'd1);
        check("memaddr", mem_addr_o, {a[31:4], 4'b0000});
        check("miss_wait_instr", instr_o, 32'd0);
        if (stall_o) stalls++;
      end
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      mem_data_i = '0;
      #1;
      check("refill_memreq", {31'd0, mem_req_o}, 32'd0);
      while (stall_o && stalls < 40) begin
        stalls++;
        @(negedge clk_i);
        #1;
      end
      check("penalty", stalls, dly + 2);
      check("retry_instr", instr_o, line_word(line, a));
      check("retry_memreq", {31'd0, mem_req_o}, 32'd0);
      m_valid[idx] = 1'b1;
      m_line[idx]  = la;
      exp_hits++;
    end
  endtask

  initial begin
    model_clear();
    do_reset();
    idle_cycle(1'b0);

    // cold miss at 0x40, ack on the third MISS cycle, then a hit on 0x48
    backing[32'h4] = {32'h44, 32'h33, 32'h22, 32'h11};
    fetch(32'h40, 3, 1'b0);
    fetch(32'h48, 1, 1'b0);
`ifdef ICACHE_STATS_EN
    @(negedge clk_i);
    req_i = 1'b0;
    #1;
    check("stats_miss", miss_cnt_o, 32'd1);
    check("stats_hit", hit_cnt_o, 32'd2);
`endif

    // conflict: 0x140 maps onto the same slot as 0x40
    fetch(32'h140, 2, 1'b0);
    fetch(32'h40, 1, 1'b0);

    // flush with a same-cycle hit, then the line is gone
    fetch(32'h44, 1, 1'b1);
    fetch(32'h44, 2, 1'b0);

    // reset in the middle of a refill
    do_reset();
    @(negedge clk_i);
    req_i = 1'b1; addr_i = 32'h40;
    #1;
    check("rm_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk_i);
    #1;
    check("rm_memreq_pre", {31'd0, mem_req_o}, 32'd1);
    rst_i = 1'b1;
    req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rm_memreq_post", {31'd0, mem_req_o}, 32'd0);
    check("rm_stall_post", {31'd0, stall_o}, 32'd0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    model_clear();
    exp_hits = 0;
    exp_misses = 0;
    fetch(32'h40, 2, 1'b0);

    // random traffic over a small address pool so hits and conflicts occur
    for (int n = 0; n < 200; n++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = {20'd0, 6'($urandom_range(0, 47)), 2'($urandom_range(0, 3)), 2'b00};
      if (r == 0)      idle_cycle(1'($urandom_range(0, 1)));
      else if (r == 1) fetch(a, int'($urandom_range(1, 4)), 1'b1);
      else             fetch(a, int'($urandom_range(1, 4)), 1'b0);
    end
    @(negedge clk_i);
    req_i = 1'b0;
    flush_i = 1'b0;
`ifdef ICACHE_STATS_EN
    #1;
    check("stats_hit_end", hit_cnt_o, exp_hits);
    check("stats_miss_end", miss_cnt_o, exp_misses);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16, number of direct-mapped lines (power of two, 4..256).
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_i  input  1  fetch request valid from IF stage.
REQ-005 SHALL have port addr_i  input  32  fetch byte address (PC), word aligned.
REQ-006 SHALL have port flush_i  input  1  invalidate all lines.
REQ-007 SHALL have port instr_o  output  32  fetched instruction.
REQ-008 SHALL have port stall_o  output  1  fetch not served; IF holds PC and IF_ID.
REQ-009 SHALL have port mem_req_o  output  1  line refill request to backing memory.
REQ-010 SHALL have port mem_addr_o  output  32  refill address, 16-byte aligned.
REQ-011 SHALL have port mem_ack_i  input  1  refill data valid, single-cycle pulse.
REQ-012 SHALL have port mem_data_i  input  128  refill line; word 0 in bits [31:0].

Function
REQ-013 SHALL split addr_i: offset [3:2], index [3+log2(NUM_LINES):4], tag = remaining upper bits.
REQ-014 SHALL implement states IDLE, MISS, REFILL.
REQ-015 SHALL, in IDLE with req_i=1 and valid+tag match, drive instr_o with the selected word combinationally and stall_o=0 (zero-cycle hit latency).
REQ-016 SHALL, in IDLE with req_i=1 and no match, drive stall_o=1, latch addr_i, and enter MISS at the next edge.
REQ-017 SHALL, in MISS, hold mem_req_o=1 and mem_addr_o={latched[31:4],4'b0} until the cycle mem_ack_i=1.
REQ-018 SHALL, on mem_ack_i=1 in MISS, write mem_data_i, tag and valid=1 into the indexed line and enter REFILL.
REQ-019 SHALL, in REFILL, drive stall_o=1 and mem_req_o=0 and return to IDLE next edge; the retried lookup then hits.
REQ-020 SHALL keep stall_o=1 throughout MISS and REFILL regardless of req_i.
REQ-021 SHALL drive instr_o=0 whenever stall_o=1 or req_i=0.
REQ-022 SHALL ignore mem_ack_i outside MISS.
REQ-023 SHALL, on flush_i=1, clear every valid bit at that edge; a hit presented in the same cycle is still served.
REQ-024 SHALL, on flush_i during MISS, still install the in-flight line as valid.
REQ-025 SHALL give miss penalty = (cycles until mem_ack_i) + 2.

Reset
REQ-026 SHALL, with rst_i=1 at an edge, enter IDLE, clear all valid bits, and drive mem_req_o=0, stall_o=0 (when req_i=0), instr_o=0.
REQ-027 SHALL abort any refill on reset mid-MISS: mem_req_o low after that edge; data arrays need not clear.

Configuration
REQ-028 SHALL honour macro ICACHE_STATS_EN: when defined, add outputs hit_cnt_o (32) and miss_cnt_o (32).
REQ-029 SHALL, with ICACHE_STATS_EN, increment hit_cnt_o per served IDLE hit and miss_cnt_o per IDLE->MISS transition, wrapping at 2^32, reset to 0.
REQ-030 SHALL, without ICACHE_STATS_EN, omit both ports and counters; all other behaviour identical.

Structure
REQ-031 SHALL place state encoding, LINE_BITS=128, OFFSET_BITS=2 and address-field helper constants in package icache_pkg.
REQ-032 SHALL isolate tag/valid/data storage in sub-module icache_array (combinational read, synchronous write, synchronous valid clear); controller FSM stays in icache_ctrl.

Verification
REQ-033 SHALL cover cold miss: reset, req_i=1, addr_i=0x40, ack after 3 cycles with data words 0x11,0x22,0x33,0x44 -> stall_o high 5 cycles, mem_addr_o=0x40, then instr_o=0x11.
REQ-034 SHALL cover hit: after REQ-033 line fill, addr_i=0x48 -> instr_o=0x33, stall_o=0 same cycle, no mem_req_o.
REQ-035 SHALL cover conflict: NUM_LINES=16, fill 0x40 then fetch 0x140 -> miss, refill; refetch 0x40 -> miss again.
REQ-036 SHALL cover flush: line 0x40 valid, flush_i pulse with req 0x44 -> 0x22 served that cycle; next-cycle fetch 0x44 -> miss.
REQ-037 SHALL cover reset mid-MISS: rst_i asserted while mem_req_o=1 -> mem_req_o=0 next cycle; late mem_ack_i ignored; 0x40 still misses.
REQ-038 SHALL cover ICACHE_STATS_EN: REQ-033..034 sequence -> miss_cnt_o=1, hit_cnt_o=2.
